// File: rtl/memif_arbiter.sv
// Round-robin arbiter sharing one mi_* memory interface between two requesters.
// One command is outstanding at a time; the owner is held until its last data beat.
module memif_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 23
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [6:0]            r0_len,
    input  logic                  r0_rw,
    input  logic                  r0_valid,
    output logic                  r0_ready,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic                  r0_wack,
    output logic                  r0_wlast,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    output logic                  r0_rstb,
    output logic                  r0_rlast,

    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [6:0]            r1_len,
    input  logic                  r1_rw,
    input  logic                  r1_valid,
    output logic                  r1_ready,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic                  r1_wack,
    output logic                  r1_wlast,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  r1_rstb,
    output logic                  r1_rlast,

    output logic [ADDR_WIDTH-1:0] mi_addr,
    output logic [6:0]            mi_len,
    output logic                  mi_rw,
    output logic                  mi_valid,
    input  logic                  mi_ready,
    output logic [DATA_WIDTH-1:0] mi_wdata,
    input  logic                  mi_wack,
    input  logic                  mi_wlast,
    input  logic [DATA_WIDTH-1:0] mi_rdata,
    input  logic                  mi_rstb,
    input  logic                  mi_rlast,

    output logic [1:0]            fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state;
    logic   owner;
    logic   prio;
    logic   rw_lat;

    logic   own_valid;
    logic   own_rw;
    logic   cmd_ack;
    logic   in_data;
    logic   burst_done;

    assign own_valid  = owner ? r1_valid : r0_valid;
    assign own_rw     = owner ? r1_rw    : r0_rw;

    // Handshake: a command transfers on a cycle where mi_valid and mi_ready are both high;
    // that same cycle is the requester's single-cycle rN_ready strobe. Data beats are
    // qualified by mi_wack / mi_rstb and only forwarded while a burst is owned.
    assign cmd_ack    = mi_valid & mi_ready;
    assign in_data    = (state == DATA);
    assign burst_done = in_data & (rw_lat ? (mi_rstb & mi_rlast) : (mi_wack & mi_wlast));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            owner  <= 1'b0;
            prio   <= 1'b0;
            rw_lat <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (r0_valid || r1_valid) begin
                        owner <= (r0_valid && r1_valid) ? prio : r1_valid;
                        state <= CMD;
                    end
                end
                CMD: begin
                    // A withdrawn request aborts without touching the tie-break.
                    if (!own_valid) begin
                        state <= IDLE;
                    end else if (mi_ready) begin
                        rw_lat <= own_rw;
                        prio   <= ~owner;
                        state  <= DATA;
                    end
                end
                DATA: begin
                    if (burst_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mi_addr   = owner ? r1_addr  : r0_addr;
    assign mi_len    = owner ? r1_len   : r0_len;
    assign mi_rw     = own_rw;
    assign mi_valid  = (state == CMD) & own_valid;
    assign mi_wdata  = owner ? r1_wdata : r0_wdata;

    assign r0_ready  = cmd_ack & ~owner;
    assign r1_ready  = cmd_ack &  owner;

    assign r0_wack   = in_data & ~owner & mi_wack;
    assign r0_wlast  = in_data & ~owner & mi_wlast;
    assign r0_rstb   = in_data & ~owner & mi_rstb;
    assign r0_rlast  = in_data & ~owner & mi_rlast;
    assign r1_wack   = in_data &  owner & mi_wack;
    assign r1_wlast  = in_data &  owner & mi_wlast;
    assign r1_rstb   = in_data &  owner & mi_rstb;
    assign r1_rlast  = in_data &  owner & mi_rlast;

    assign r0_rdata  = mi_rdata;
    assign r1_rdata  = mi_rdata;

    assign fsm_state = state;

endmodule

// File: tb/tb_memif_arbiter.sv
// Directed bench for memif_arbiter: the memory controller side is driven by hand
// and every expected value below is worked out from the intended behaviour.
module tb_memif_arbiter;

    localparam int DW = 16;
    localparam int AW = 23;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] r0_addr, r1_addr, mi_addr;
    logic [6:0]    r0_len, r1_len, mi_len;
    logic          r0_rw, r1_rw, mi_rw;
    logic          r0_valid, r1_valid, mi_valid;
    logic          r0_ready, r1_ready, mi_ready;
    logic [DW-1:0] r0_wdata, r1_wdata, mi_wdata;
    logic          r0_wack, r0_wlast, r1_wack, r1_wlast, mi_wack, mi_wlast;
    logic [DW-1:0] r0_rdata, r1_rdata, mi_rdata;
    logic          r0_rstb, r0_rlast, r1_rstb, r1_rlast, mi_rstb, mi_rlast;
    logic [1:0]    fsm_state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memif_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_addr(r0_addr), .r0_len(r0_len), .r0_rw(r0_rw), .r0_valid(r0_valid),
        .r0_ready(r0_ready), .r0_wdata(r0_wdata), .r0_wack(r0_wack), .r0_wlast(r0_wlast),
        .r0_rdata(r0_rdata), .r0_rstb(r0_rstb), .r0_rlast(r0_rlast),
        .r1_addr(r1_addr), .r1_len(r1_len), .r1_rw(r1_rw), .r1_valid(r1_valid),
        .r1_ready(r1_ready), .r1_wdata(r1_wdata), .r1_wack(r1_wack), .r1_wlast(r1_wlast),
        .r1_rdata(r1_rdata), .r1_rstb(r1_rstb), .r1_rlast(r1_rlast),
        .mi_addr(mi_addr), .mi_len(mi_len), .mi_rw(mi_rw), .mi_valid(mi_valid),
        .mi_ready(mi_ready), .mi_wdata(mi_wdata), .mi_wack(mi_wack), .mi_wlast(mi_wlast),
        .mi_rdata(mi_rdata), .mi_rstb(mi_rstb), .mi_rlast(mi_rlast),
        .fsm_state(fsm_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Move just past the next rising edge, then let combinational outputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_mi_data();
        mi_wack = 1'b0; mi_wlast = 1'b0; mi_rstb = 1'b0; mi_rlast = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        r0_addr  = 23'h012345; r0_len = 7'd63; r0_rw = 1'b0; r0_valid = 1'b0; r0_wdata = 16'hbeef;
        r1_addr  = 23'h6abcde; r1_len = 7'd0;  r1_rw = 1'b1; r1_valid = 1'b0; r1_wdata = 16'h1234;
        mi_ready = 1'b0; mi_rdata = 16'h0000;
        clear_mi_data();

        // Reset state
        #2;
        chk("rst_state", 32'(fsm_state), 32'(S_IDLE));
        chk("rst_mi_valid", 32'(mi_valid), 32'd0);
        chk("rst_ready", 32'({r0_ready, r1_ready}), 32'd0);
        tick();
        rst_n = 1'b1;

        // 1: lone r0 write, len 63
        r0_valid = 1'b1;
        settle();
        chk("t1_idle_no_valid", 32'(mi_valid), 32'd0);
        tick();
        chk("t1_cmd_state", 32'(fsm_state), 32'(S_CMD));
        chk("t1_cmd_valid", 32'(mi_valid), 32'd1);
        chk("t1_cmd_addr", 32'(mi_addr), 32'h012345);
        chk("t1_cmd_len", 32'(mi_len), 32'd63);
        chk("t1_cmd_rw", 32'(mi_rw), 32'd0);
        chk("t1_ready_wait", 32'({r0_ready, r1_ready}), 32'd0);
        mi_ready = 1'b1;
        settle();
        chk("t1_ready", 32'({r0_ready, r1_ready}), 32'b10);
        tick();
        mi_ready = 1'b0; r0_valid = 1'b0;
        settle();
        chk("t1_data_state", 32'(fsm_state), 32'(S_DATA));
        chk("t1_data_valid", 32'(mi_valid), 32'd0);
        chk("t1_wdata", 32'(mi_wdata), 32'hbeef);
        for (int i = 0; i < 64; i++) begin
            mi_wack = 1'b1; mi_wlast = (i == 63);
            settle();
            chk("t1_r0_wack", 32'(r0_wack), 32'd1);
            chk("t1_r1_wack", 32'(r1_wack), 32'd0);
            chk("t1_r0_wlast", 32'(r0_wlast), 32'(i == 63));
            chk("t1_in_data", 32'(fsm_state), 32'(S_DATA));
            tick();
        end
        clear_mi_data();
        chk("t1_end_idle", 32'(fsm_state), 32'(S_IDLE));

        // 2: simultaneous requests after reset alternate 0,1,0
        do_reset();
        r0_len = 7'd0; r1_len = 7'd0;
        r0_valid = 1'b1; r1_valid = 1'b1;
        tick();
        chk("t2_g0_addr", 32'(mi_addr), 32'h012345);
        mi_ready = 1'b1;
        settle();
        chk("t2_g0_ready", 32'({r0_ready, r1_ready}), 32'b10);
        tick();
        mi_ready = 1'b0;
        mi_wack = 1'b1; mi_wlast = 1'b1;
        settle();
        chk("t2_g0_wack", 32'({r0_wack, r1_wack}), 32'b10);
        tick();
        clear_mi_data();
        chk("t2_gap_idle", 32'(fsm_state), 32'(S_IDLE));
        chk("t2_gap_ready", 32'({r0_ready, r1_ready}), 32'd0);
        tick();
        chk("t2_g1_addr", 32'(mi_addr), 32'h6abcde);
        chk("t2_g1_rw", 32'(mi_rw), 32'd1);
        mi_ready = 1'b1;
        settle();
        chk("t2_g1_ready", 32'({r0_ready, r1_ready}), 32'b01);
        tick();
        mi_ready = 1'b0;
        mi_rstb = 1'b1; mi_rlast = 1'b1; mi_rdata = 16'hc0de;
        settle();
        chk("t2_g1_rstb", 32'({r0_rstb, r1_rstb}), 32'b01);
        chk("t2_rdata_bcast", 32'(r0_rdata), 32'hc0de);
        tick();
        clear_mi_data();
        tick();
        chk("t2_g2_state", 32'(fsm_state), 32'(S_CMD));
        chk("t2_g2_addr", 32'(mi_addr), 32'h012345);

        // 4: owner withdraws in CMD -> abort, tie-break stays with r0
        r0_valid = 1'b0;
        settle();
        chk("t4_abort_valid", 32'(mi_valid), 32'd0);
        chk("t4_abort_ready", 32'({r0_ready, r1_ready}), 32'd0);
        tick();
        chk("t4_abort_idle", 32'(fsm_state), 32'(S_IDLE));
        r0_valid = 1'b1;
        tick();
        chk("t4_prio_kept", 32'(mi_addr), 32'h012345);
        r0_valid = 1'b0;
        tick();
        chk("t4_abort2_idle", 32'(fsm_state), 32'(S_IDLE));

        // 3: r1 read, len 3
        r1_len = 7'd3;
        tick();
        chk("t3_cmd_addr", 32'(mi_addr), 32'h6abcde);
        chk("t3_cmd_len", 32'(mi_len), 32'd3);
        mi_ready = 1'b1;
        tick();
        mi_ready = 1'b0; r1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mi_rstb = 1'b1; mi_rlast = (i == 3); mi_rdata = 16'(16'h0100 + i);
            settle();
            chk("t3_r1_rstb", 32'(r1_rstb), 32'd1);
            chk("t3_r0_rstb", 32'(r0_rstb), 32'd0);
            chk("t3_r1_rlast", 32'(r1_rlast), 32'(i == 3));
            chk("t3_r1_rdata", 32'(r1_rdata), 32'h0100 + 32'(i));
            tick();
        end
        clear_mi_data();
        chk("t3_end_idle", 32'(fsm_state), 32'(S_IDLE));

        // 5: reset mid-write at beat 10
        r0_len = 7'd63; r0_valid = 1'b1;
        tick();
        mi_ready = 1'b1;
        tick();
        mi_ready = 1'b0; r0_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mi_wack = 1'b1;
            tick();
        end
        settle();
        chk("t5_beat10_wack", 32'(r0_wack), 32'd1);
        rst_n = 1'b0;
        settle();
        chk("t5_rst_state", 32'(fsm_state), 32'(S_IDLE));
        chk("t5_rst_wack", 32'({r0_wack, r1_wack}), 32'd0);
        chk("t5_rst_valid", 32'(mi_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        clear_mi_data();
        r1_valid = 1'b1; r1_rw = 1'b0; r1_len = 7'd0;
        tick();
        chk("t5_regrant_valid", 32'(mi_valid), 32'd1);
        chk("t5_regrant_addr", 32'(mi_addr), 32'h6abcde);
        chk("t5_regrant_wdata", 32'(mi_wdata), 32'h1234);
        mi_ready = 1'b1;
        tick();
        mi_ready = 1'b0; r1_valid = 1'b0;
        mi_wack = 1'b1; mi_wlast = 1'b1;
        settle();
        chk("t5_regrant_wack", 32'({r0_wack, r1_wack}), 32'b01);
        tick();
        clear_mi_data();
        chk("t5_end_idle", 32'(fsm_state), 32'(S_IDLE));

        // 6: spurious data strobes while idle
        mi_wack = 1'b1; mi_wlast = 1'b1; mi_rstb = 1'b1; mi_rlast = 1'b1;
        settle();
        chk("t6_wack", 32'({r0_wack, r1_wack}), 32'd0);
        chk("t6_rstb", 32'({r0_rstb, r1_rstb}), 32'd0);
        chk("t6_last", 32'({r0_wlast, r1_wlast, r0_rlast, r1_rlast}), 32'd0);
        tick();
        chk("t6_state", 32'(fsm_state), 32'(S_IDLE));
        clear_mi_data();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
